// File: rtl/nibble_alu_pkg.sv
// Shared constants, op encodings, FSM state enum and op-decode helpers for the nibble-serial ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional SLT support is selected by the NIBBLE_ALU_SLT_EN macro.
package nibble_alu_pkg;

  localparam int DATA_W  = 32;
  localparam int SLICE_W = 4;
  localparam int NIBBLES = DATA_W / SLICE_W;  // 8

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  // Function applied by the shared 4-bit slice.
  typedef enum logic [1:0] {
    SL_ADD = 2'd0,
    SL_AND = 2'd1,
    SL_OR  = 2'd2,
    SL_XOR = 2'd3
  } slice_fn_e;

`ifdef NIBBLE_ALU_SLT_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    SLT_FIX = 2'd2,
    DONE    = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
`endif

  function automatic logic op_legal(input logic [2:0] o);
    logic ok;
    ok = 1'b0;
    case (o)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: ok = 1'b1;
`ifdef NIBBLE_ALU_SLT_EN
      OP_SLT: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // SUB and SLT compute A + ~B + 1.
  function automatic logic op_inv_b(input logic [2:0] o);
    return (o == OP_SUB) || (o == OP_SLT);
  endfunction

  function automatic slice_fn_e op_slice_fn(input logic [2:0] o);
    slice_fn_e fn;
    case (o)
      OP_AND:  fn = SL_AND;
      OP_OR:   fn = SL_OR;
      OP_XOR:  fn = SL_XOR;
      default: fn = SL_ADD;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/nibble_alu_slice.sv
// Combinational 4-bit ADD/AND/OR/XOR slice shared across all nibbles of a serial operation.
// Latency: 0 (purely combinational).
// Backpressure: none; outputs follow inputs.
// Ports: fn (slice function), x/y (operand nibbles), cin (carry in),
//        sum (nibble result), cout (carry out of bit 3), c3 (carry into bit 3).
module nibble_alu_slice
  import nibble_alu_pkg::*;
(
  input  slice_fn_e            fn,
  input  logic [SLICE_W-1:0]   x,
  input  logic [SLICE_W-1:0]   y,
  input  logic                 cin,
  output logic [SLICE_W-1:0]   sum,
  output logic                 cout,
  output logic                 c3
);

  logic [SLICE_W:0]   full;  // x + y + cin, with carry out
  logic [SLICE_W-1:0] low;   // low three bits only; MSB is the carry into bit 3

  always_comb begin
    full = {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, cin};
    low  = {1'b0, x[SLICE_W-2:0]} + {1'b0, y[SLICE_W-2:0]} + {{(SLICE_W-1){1'b0}}, cin};
    sum  = full[SLICE_W-1:0];
    cout = 1'b0;
    c3   = 1'b0;
    case (fn)
      SL_ADD: begin
        sum  = full[SLICE_W-1:0];
        cout = full[SLICE_W];
        c3   = low[SLICE_W-1];
      end
      SL_AND:  sum = x & y;
      SL_OR:   sum = x | y;
      SL_XOR:  sum = x ^ y;
      default: sum = full[SLICE_W-1:0];
    endcase
  end

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// Runs a 32-bit ALU op through one shared 4-bit slice, one nibble per clock.
// Latency: 9 cycles start->done (10 for SLT, 2 for an illegal op).
// Backpressure: start is ignored while busy; no queueing. Macro NIBBLE_ALU_SLT_EN enables op 101 = SLT.
// Ports: clk, rst_n (async active-low); start/op/a/b request; busy, done (1-cycle pulse),
//        result, carry_out, zero, illegal (held from done until the next accepted start).
module nibble_serial_alu_ctrl
  import nibble_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              zero,
  output logic              illegal
);

  state_e              state, state_n;
  logic [2:0]          cnt;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;     // already inverted for SUB/SLT
  logic [2:0]          op_q;
  logic                carry_q;

  logic                accept;
  logic                last;
  logic                legal_q;
  logic                arith_q;
  logic                slt_op;

  logic [SLICE_W-1:0]  slice_sum;
  logic                slice_cout;
  logic                slice_c3;

`ifdef NIBBLE_ALU_SLT_EN
  logic                ovf_q;
  assign slt_op = (op_q == OP_SLT);
`else
  assign slt_op = 1'b0;
`endif

  assign accept  = start && ((state == IDLE) || (state == DONE));
  assign last    = (cnt == 3'(NIBBLES - 1));
  assign legal_q = op_legal(op_q);
  assign arith_q = (op_q == OP_ADD) || (op_q == OP_SUB);

  nibble_alu_slice u_slice (
    .fn   (op_slice_fn(op_q)),
    .x    (a_q[{cnt, 2'b00} +: SLICE_W]),
    .y    (b_q[{cnt, 2'b00} +: SLICE_W]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
`ifdef NIBBLE_ALU_SLT_EN
    .c3   (slice_c3)
`else
    .c3   ()
`endif
  );

`ifndef NIBBLE_ALU_SLT_EN
  assign slice_c3 = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and status outputs.
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        busy = 1'b1;
        // An illegal op skips the nibble walk entirely.
        if (!legal_q) begin
          state_n = DONE;
        end else if (last) begin
`ifdef NIBBLE_ALU_SLT_EN
          state_n = slt_op ? SLT_FIX : DONE;
`else
          state_n = DONE;
`endif
        end
      end
`ifdef NIBBLE_ALU_SLT_EN
      SLT_FIX: begin
        busy    = 1'b1;
        state_n = DONE;
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_n = start ? RUN : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, nibble walk and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_ADD;
      carry_q   <= 1'b0;
      cnt       <= 3'd0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
`ifdef NIBBLE_ALU_SLT_EN
      ovf_q     <= 1'b0;
`endif
    end else if (accept) begin
      a_q       <= a;
      b_q       <= op_inv_b(op) ? ~b : b;
      op_q      <= op;
      carry_q   <= op_inv_b(op);  // the +1 of two's-complement subtraction
      cnt       <= 3'd0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!legal_q) begin
            result    <= '0;
            illegal   <= 1'b1;
            carry_out <= 1'b0;
            zero      <= 1'b1;
          end else begin
            result[{cnt, 2'b00} +: SLICE_W] <= slice_sum;
            carry_q <= slice_cout;
            cnt     <= cnt + 3'd1;
            if (last) begin
`ifdef NIBBLE_ALU_SLT_EN
              // Signed overflow of A-B: carry into bit 31 differs from carry out.
              ovf_q <= slice_c3 ^ slice_cout;
`endif
              // SLT flags are produced in the fix-up cycle instead.
              if (!slt_op) begin
                carry_out <= arith_q ? slice_cout : 1'b0;
                zero      <= ({slice_sum, result[DATA_W-SLICE_W-1:0]} == '0);
              end
            end
          end
        end
`ifdef NIBBLE_ALU_SLT_EN
        SLT_FIX: begin
          // A < B (signed) is the sign of A-B corrected by overflow.
          result    <= {{(DATA_W-1){1'b0}}, result[DATA_W-1] ^ ovf_q};
          carry_out <= 1'b0;
          zero      <= ~(result[DATA_W-1] ^ ovf_q);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
